voice_sample_source: RTL and testbench
======================================

VOICE_SAMPLE_SOURCE -- requirements
Module: voice_sample_source

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1024, clocks per output sample; even, >= 8.
REQ-002 SHALL have parameter PHASE_W, default 24, phase accumulator width.
REQ-003 SHALL have one clock and an asynchronous active-low reset.
REQ-004 Port: inClock  input  1  sole clock; all state updates on rising edge.
REQ-005 Port: inResetN  input  1  asynchronous, active-low reset.
REQ-006 Port: inNoteValid  input  1  note command present.
REQ-007 Port: outNoteReady  output  1  command accepted when inNoteValid && outNoteReady at a rising edge.
REQ-008 Port: inNoteOn  input  1  command type: 1 = note-on, 0 = note-off; sampled only on accept.
REQ-009 Port: inPhaseStep  input  PHASE_W  per-sample phase increment (pitch); sampled only on accepted note-on.
REQ-010 Port: inWaveSel  input  2  waveform (0 saw, 1 square, 2 triangle, 3 mid-level 2048); sampled only on accepted note-on.
REQ-011 Port: outSample  output  12  unsigned sample, registered.
REQ-012 Port: outSampleReady  output  1  sample strobe; consumers capture on its rising edge.
REQ-013 Port: outIsPlaying  output  1  gate; high between applied note-on and applied note-off.

Function
REQ-014 SHALL run free-running counter cnt 0..CLK_DIV-1; tick = edge where cnt wraps CLK_DIV-1 -> 0; counting never pauses, including when idle.
REQ-015 On every tick SHALL update outSample; the strobe is never suppressed, so a downstream envelope can release after note-off.
REQ-016 outSampleReady SHALL be high exactly while cnt is 1..CLK_DIV/2 and low otherwise; its rise is one clock after the sample update, so outSample and outIsPlaying are stable at the rise.
REQ-017 On a plain tick SHALL set phase <= phase + step mod 2^PHASE_W (wrap silently) and outSample <= wave(new phase).
REQ-018 Let P = phase. Saw: P[PHASE_W-1 -: 12]. Square: P[MSB] ? 4095 : 0. Triangle: u = P[PHASE_W-2 -: 12]; P[MSB] ? 4095-u : u. Sel 3: constant 2048.
REQ-019 SHALL use FSM states IDLE, START_PEND, PLAYING, STOP_PEND.
REQ-020 outNoteReady SHALL be 1 in IDLE and PLAYING and 0 in START_PEND and STOP_PEND.
REQ-021 IDLE + accepted note-on: latch step/wave, go to START_PEND.
REQ-022 IDLE + accepted note-off: ignore the command and stay in IDLE.
REQ-023 START_PEND at tick: phase <= 0, outSample <= wave(0), outIsPlaying <= 1, go to PLAYING.
REQ-024 PLAYING + accepted note-on (legato): latch step/wave, go to START_PEND'; at the next tick apply the new step/wave without phase reset (phase+newstep), return to PLAYING; outIsPlaying stays 1.
REQ-025 PLAYING + accepted note-off: go to STOP_PEND.
REQ-026 STOP_PEND at tick: outIsPlaying <= 0, plain phase advance, go to IDLE.
REQ-027 A command accepted on a tick edge SHALL take effect at the following tick, never on the same tick.
REQ-028 In IDLE the phase SHALL keep advancing with the last latched step and wave.
REQ-029 The step/wave latch SHALL reset to 0, so idle output after reset is saw at phase 0, i.e. 0.

Reset
REQ-030 While inResetN = 0: cnt = 0, phase = 0, step = 0, wave = 0, FSM = IDLE, outSample = 0, outSampleReady = 0, outIsPlaying = 0, outNoteReady = 0.
REQ-031 outNoteReady SHALL rise on the first clock edge after reset release.
REQ-032 Reset asserted mid-note SHALL drop outIsPlaying and outSampleReady immediately, with no pending command surviving.

Verification (CLK_DIV = 8, PHASE_W = 24)
REQ-033 Reset release, idle -> outSample 0; outSampleReady high for cnt 1..4, period 8 clocks; outIsPlaying 0.
REQ-034 Note-on step 0x100000, saw -> outNoteReady low until the tick; at the tick outIsPlaying 1, outSample 0; the next ticks give 0x100, 0x200, ...
REQ-035 Note-on step 0x400000, square -> successive samples 0, 0, 4095, 4095, 0 (phase wrap).
REQ-036 Note-off while playing -> outIsPlaying falls at the next tick, outSampleReady keeps toggling, and the phase keeps advancing.
REQ-037 Legato note-on step 0x200000 from phase 0x300000 -> no phase reset; the next sample is saw 0x500; outIsPlaying stays 1.
REQ-038 inResetN pulsed low mid-note -> all outputs 0 asynchronously; after release, behaviour matches REQ-033.

Source files
------------

// File: rtl/voice_sample_source.sv
// Voice sample source: phase-accumulator oscillator with a note
// command handshake, free-running sample tick and half-period strobe.
module voice_sample_source #(
    parameter int CLK_DIV = 1024,
    parameter int PHASE_W = 24
) (
    input  logic               inClock,
    input  logic               inResetN,
    input  logic               inNoteValid,
    output logic               outNoteReady,
    input  logic               inNoteOn,
    input  logic [PHASE_W-1:0] inPhaseStep,
    input  logic [1:0]         inWaveSel,
    output logic [11:0]        outSample,
    output logic               outSampleReady,
    output logic               outIsPlaying
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2);

    typedef enum logic [1:0] {
        IDLE,
        START_PEND,
        PLAYING,
        STOP_PEND
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] w_phase_nxt;
    logic [PHASE_W-1:0] r_step;
    logic [1:0]         r_wave;
    logic               r_legato;
    logic               w_legato_nxt;
    logic               w_latch;
    logic               w_tick;
    logic               w_accept;
    logic               w_playing_nxt;
    logic [11:0]        r_sample;
    logic               r_strobe;
    logic               r_playing;
    logic               r_note_rdy;

    function automatic logic [11:0] f_wave(
        input logic [PHASE_W-1:0] p,
        input logic [1:0]         sel
    );
        logic [11:0] u;
        u = p[PHASE_W-2 -: 12];
        f_wave = 12'd0;
        unique case (sel)
            2'd0: f_wave = p[PHASE_W-1 -: 12];
            2'd1: f_wave = p[PHASE_W-1] ? 12'd4095 : 12'd0;
            2'd2: f_wave = p[PHASE_W-1] ? (12'd4095 - u) : u;
            2'd3: f_wave = 12'd2048;
        endcase
    endfunction

    assign w_tick    = (r_cnt == CNT_LAST);
    assign w_cnt_nxt = w_tick ? '0 : r_cnt + CNT_W'(1);
    assign w_accept  = inNoteValid && r_note_rdy;

    always_comb begin
        w_state_nxt   = r_state;
        w_legato_nxt  = r_legato;
        w_latch       = 1'b0;
        w_playing_nxt = r_playing;
        w_phase_nxt   = r_phase + r_step;
        unique case (r_state)
            IDLE: begin
                if (w_accept && inNoteOn) begin
                    w_state_nxt  = START_PEND;
                    w_legato_nxt = 1'b0;
                    w_latch      = 1'b1;
                end
            end
            PLAYING: begin
                if (w_accept && inNoteOn) begin
                    w_state_nxt  = START_PEND;
                    w_legato_nxt = 1'b1;
                    w_latch      = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = STOP_PEND;
                end
            end
            START_PEND: begin
                if (w_tick) begin
                    w_state_nxt   = PLAYING;
                    w_playing_nxt = 1'b1;
                    if (!r_legato) w_phase_nxt = '0;
                end
            end
            STOP_PEND: begin
                if (w_tick) begin
                    w_state_nxt   = IDLE;
                    w_playing_nxt = 1'b0;
                end
            end
        endcase
    end

    // Sample and gate only move on the tick; the strobe rises one clock later.
    always_ff @(posedge inClock or negedge inResetN) begin
        if (!inResetN) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_phase    <= '0;
            r_step     <= '0;
            r_wave     <= 2'd0;
            r_legato   <= 1'b0;
            r_sample   <= 12'd0;
            r_strobe   <= 1'b0;
            r_playing  <= 1'b0;
            r_note_rdy <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_legato   <= w_legato_nxt;
            r_strobe   <= (w_cnt_nxt != '0) && (w_cnt_nxt <= CNT_HALF);
            r_note_rdy <= (w_state_nxt == IDLE) || (w_state_nxt == PLAYING);
            if (w_latch) begin
                r_step <= inPhaseStep;
                r_wave <= inWaveSel;
            end
            if (w_tick) begin
                r_phase   <= w_phase_nxt;
                r_sample  <= f_wave(w_phase_nxt, r_wave);
                r_playing <= w_playing_nxt;
            end
        end
    end

    assign outNoteReady   = r_note_rdy;
    assign outSample      = r_sample;
    assign outSampleReady = r_strobe;
    assign outIsPlaying   = r_playing;

endmodule

// File: tb/tb_voice_sample_source.sv
// Directed bench for voice_sample_source at CLK_DIV=8, PHASE_W=24:
// one table row per sample tick, plus reset and strobe-timing sequences.
module tb_voice_sample_source;

    localparam int CLK_DIV = 8;
    localparam int PHASE_W = 24;

    logic               inClock = 1'b0;
    logic               inResetN = 1'b0;
    logic               inNoteValid = 1'b0;
    logic               outNoteReady;
    logic               inNoteOn = 1'b0;
    logic [PHASE_W-1:0] inPhaseStep = '0;
    logic [1:0]         inWaveSel = 2'd0;
    logic [11:0]        outSample;
    logic               outSampleReady;
    logic               outIsPlaying;

    int n_checks = 0;
    int n_errors = 0;

    voice_sample_source #(
        .CLK_DIV(CLK_DIV),
        .PHASE_W(PHASE_W)
    ) dut (
        .inClock       (inClock),
        .inResetN      (inResetN),
        .inNoteValid   (inNoteValid),
        .outNoteReady  (outNoteReady),
        .inNoteOn      (inNoteOn),
        .inPhaseStep   (inPhaseStep),
        .inWaveSel     (inWaveSel),
        .outSample     (outSample),
        .outSampleReady(outSampleReady),
        .outIsPlaying  (outIsPlaying)
    );

    always #5 inClock = ~inClock;

    // cmd: 0 none, 1 note-on, 2 note-off
    typedef struct {
        logic [1:0]  cmd;
        logic [23:0] step;
        logic [1:0]  wsel;
        logic        nrdy;
        logic [11:0] smp;
        logic        play;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_rise(input string name);
        logic prev;
        bit   seen;
        prev = outSampleReady;
        seen = 1'b0;
        for (int i = 0; i < 32 && !seen; i++) begin
            @(negedge inClock);
            if (!prev && outSampleReady) seen = 1'b1;
            prev = outSampleReady;
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: strobe rise timeout got 0 expected 1", name);
        end
    endtask

    task automatic send(input logic [1:0] cmd, input logic [23:0] step,
                        input logic [1:0] wsel, input logic exp_nrdy,
                        input string name);
        bit acc;
        acc = 1'b0;
        inNoteValid = 1'b1;
        inNoteOn    = (cmd == 2'd1);
        inPhaseStep = step;
        inWaveSel   = wsel;
        for (int i = 0; i < 32 && !acc; i++) begin
            acc = outNoteReady;
            @(posedge inClock);
        end
        #1;
        inNoteValid = 1'b0;
        inPhaseStep = '0;
        inWaveSel   = 2'd0;
        chk({name, " accepted"}, 32'(acc), 32'd1);
        @(negedge inClock);
        chk({name, " noteReady after accept"}, 32'(outNoteReady),
            32'(exp_nrdy));
    endtask

    task automatic chk_period(input string name);
        int  hi;
        int  n;
        logic prev;
        bit  done;
        hi = 1;
        n = 0;
        prev = outSampleReady;
        done = 1'b0;
        for (int i = 0; i < 32 && !done; i++) begin
            @(negedge inClock);
            n++;
            if (outSampleReady && !prev) done = 1'b1;
            else if (outSampleReady) hi++;
            prev = outSampleReady;
        end
        chk({name, " strobe period"}, 32'(n), 32'd8);
        chk({name, " strobe high clocks"}, 32'(hi), 32'd4);
    endtask

    initial begin
        tbl[0]  = '{2'd0, 24'h000000, 2'd0, 1'b0, 12'd0,    1'b0};
        tbl[1]  = '{2'd1, 24'h100000, 2'd0, 1'b0, 12'd0,    1'b1};
        tbl[2]  = '{2'd0, 24'h000000, 2'd0, 1'b0, 12'h100,  1'b1};
        tbl[3]  = '{2'd0, 24'h000000, 2'd0, 1'b0, 12'h200,  1'b1};
        tbl[4]  = '{2'd0, 24'h000000, 2'd0, 1'b0, 12'h300,  1'b1};
        tbl[5]  = '{2'd1, 24'h200000, 2'd0, 1'b0, 12'h500,  1'b1};
        tbl[6]  = '{2'd2, 24'h000000, 2'd0, 1'b0, 12'h700,  1'b0};
        tbl[7]  = '{2'd0, 24'h000000, 2'd0, 1'b0, 12'h900,  1'b0};
        tbl[8]  = '{2'd1, 24'h400000, 2'd1, 1'b0, 12'd0,    1'b1};
        tbl[9]  = '{2'd0, 24'h000000, 2'd0, 1'b0, 12'd0,    1'b1};
        tbl[10] = '{2'd0, 24'h000000, 2'd0, 1'b0, 12'd4095, 1'b1};
        tbl[11] = '{2'd0, 24'h000000, 2'd0, 1'b0, 12'd4095, 1'b1};
        tbl[12] = '{2'd0, 24'h000000, 2'd0, 1'b0, 12'd0,    1'b1};
        tbl[13] = '{2'd1, 24'h100000, 2'd2, 1'b0, 12'd512,  1'b1};
        tbl[14] = '{2'd0, 24'h000000, 2'd0, 1'b0, 12'd1024, 1'b1};
        tbl[15] = '{2'd1, 24'h700000, 2'd2, 1'b0, 12'd3583, 1'b1};
        tbl[16] = '{2'd1, 24'h000000, 2'd3, 1'b0, 12'd2048, 1'b1};
        tbl[17] = '{2'd2, 24'h000000, 2'd0, 1'b0, 12'd2048, 1'b0};
        tbl[18] = '{2'd2, 24'h000000, 2'd0, 1'b1, 12'd2048, 1'b0};

        repeat (3) @(negedge inClock);
        #1;
        chk("reset sample", 32'(outSample), 32'd0);
        chk("reset strobe", 32'(outSampleReady), 32'd0);
        chk("reset playing", 32'(outIsPlaying), 32'd0);
        chk("reset noteReady", 32'(outNoteReady), 32'd0);
        @(negedge inClock);
        inResetN = 1'b1;

        wait_rise("first rise");
        chk("idle sample", 32'(outSample), 32'd0);
        chk("idle playing", 32'(outIsPlaying), 32'd0);
        chk("idle noteReady", 32'(outNoteReady), 32'd1);
        chk_period("idle");

        for (int i = 0; i < 19; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            if (tbl[i].cmd != 2'd0)
                send(tbl[i].cmd, tbl[i].step, tbl[i].wsel, tbl[i].nrdy, nm);
            wait_rise(nm);
            chk({nm, " sample"}, 32'(outSample), 32'(tbl[i].smp));
            chk({nm, " playing"}, 32'(outIsPlaying), 32'(tbl[i].play));
            chk({nm, " noteReady"}, 32'(outNoteReady), 32'd1);
        end
        chk_period("after note-off");

        // Reset in the middle of a note with a command still pending
        send(2'd1, 24'h100000, 2'd0, 1'b0, "rst on");
        wait_rise("rst on");
        chk("rst on playing", 32'(outIsPlaying), 32'd1);
        send(2'd1, 24'h200000, 2'd1, 1'b0, "rst pend");
        #2;
        chk("pre-reset strobe", 32'(outSampleReady), 32'd1);
        inResetN = 1'b0;
        #1;
        chk("mid reset sample", 32'(outSample), 32'd0);
        chk("mid reset strobe", 32'(outSampleReady), 32'd0);
        chk("mid reset playing", 32'(outIsPlaying), 32'd0);
        chk("mid reset noteReady", 32'(outNoteReady), 32'd0);
        repeat (2) @(negedge inClock);
        inResetN = 1'b1;
        wait_rise("post reset");
        chk("post reset sample", 32'(outSample), 32'd0);
        chk("post reset playing", 32'(outIsPlaying), 32'd0);
        chk("post reset noteReady", 32'(outNoteReady), 32'd1);
        chk_period("post reset");
        wait_rise("post reset 2");
        chk("post reset 2 sample", 32'(outSample), 32'd0);
        chk("post reset 2 playing", 32'(outIsPlaying), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
